// File: rtl/cpu_defines.sv
// Shared decode constants, FSM encoding and bus-lane helpers for the memory stage.
package cpu_defines;

  localparam logic [6:0] INST_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] INST_TYPE_STORE = 7'b0100011;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        valid;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        bus_err;
  } wb_bundle_t;

  // funct3[1:0] alone selects the access width for both loads and stores.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input mem_size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module mem_load_align
  import cpu_defines::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      INST_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
      INST_LH:  result_o = {{16{half_sel[15]}}, half_sel};
      INST_LBU: result_o = {24'd0, byte_sel};
      INST_LHU: result_o = {16'd0, half_sel};
      default:  result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU passthrough plus load/store over a req/gnt/rvalid bus.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking the low bits.
module mem_stage
  import cpu_defines::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_rd_en,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        flush,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        out_valid,
  output logic        out_rd_en,
  output logic [4:0]  out_rd_addr,
  output logic [31:0] out_wdata,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_bus_err,
  output logic        fwd_en,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
);

  localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (RESP_TIMEOUT == 0) ? '0 : CNT_W'(RESP_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        is_store_q, is_store_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  wb_bundle_t  out_q, out_d;

  logic        is_ld, is_st, accept, in_rd_gated, trap;
  mem_size_e   in_size;
  logic [1:0]  in_lo;
  logic [31:0] load_data;

  assign is_ld       = (in_inst[6:0] == INST_TYPE_LOAD);
  assign is_st       = (in_inst[6:0] == INST_TYPE_STORE);
  assign in_ready    = (state_q == IDLE);
  assign accept      = in_valid & in_ready & ~flush;
  assign in_rd_gated = in_rd_en & (in_rd_addr != 5'd0);
  assign in_size     = f3_size(in_inst[14:12]);
  assign in_lo       = align_lo(in_size, in_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (is_ld | is_st) & misaligned(in_size, in_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  mem_load_align u_align (
    .rdata_i   (dbus_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .result_o  (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    is_store_d  = is_store_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    out_d       = out_q;
    out_d.valid = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (trap) begin
            out_d = '{valid: 1'b1, rd_en: 1'b0, rd_addr: in_rd_addr, wdata: 32'd0,
                      pc: in_pc, inst: in_inst, bus_err: 1'b1};
          end else if (is_ld | is_st) begin
            state_d     = REQ;
            funct3_d    = in_inst[14:12];
            addr_lo_d   = in_lo;
            is_store_d  = is_st;
            rd_en_d     = is_ld & in_rd_gated;
            rd_addr_d   = in_rd_addr;
            pc_d        = in_pc;
            inst_d      = in_inst;
            bus_we_d    = is_st;
            bus_addr_d  = {in_result[31:2], 2'b00};
            bus_be_d    = byte_en(in_size, in_lo);
            bus_wdata_d = lane_data(in_size, in_store_data);
          end else begin
            out_d = '{valid: 1'b1, rd_en: in_rd_gated, rd_addr: in_rd_addr, wdata: in_result,
                      pc: in_pc, inst: in_inst, bus_err: 1'b0};
          end
        end
      end
      REQ: begin
        // Once granted the access is committed; a same-cycle flush only hides the result.
        if (dbus_gnt) begin
          if (is_store_q) begin
            state_d = IDLE;
            if (!flush) begin
              out_d = '{valid: 1'b1, rd_en: 1'b0, rd_addr: rd_addr_q, wdata: 32'd0,
                        pc: pc_q, inst: inst_q, bus_err: 1'b0};
            end
          end else begin
            state_d = flush ? DRAIN : WAIT;
            cnt_d   = '0;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dbus_rvalid) begin
          state_d = IDLE;
          if (!flush) begin
            out_d = '{valid: 1'b1, rd_en: rd_en_q, rd_addr: rd_addr_q, wdata: load_data,
                      pc: pc_q, inst: inst_q, bus_err: 1'b0};
          end
        end else if (flush) begin
          state_d = DRAIN;
        end else if ((RESP_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = DRAIN;
          out_d = '{valid: 1'b1, rd_en: 1'b0, rd_addr: rd_addr_q, wdata: 32'd0,
                    pc: pc_q, inst: inst_q, bus_err: 1'b1};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dbus_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      is_store_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pc_q        <= '0;
      inst_q      <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      is_store_q  <= is_store_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      out_q       <= out_d;
    end
  end

  assign dbus_req    = (state_q == REQ);
  assign dbus_we     = bus_we_q;
  assign dbus_addr   = bus_addr_q;
  assign dbus_be     = bus_be_q;
  assign dbus_wdata  = bus_wdata_q;
  assign out_valid   = out_q.valid;
  assign out_rd_en   = out_q.rd_en;
  assign out_rd_addr = out_q.rd_addr;
  assign out_wdata   = out_q.wdata;
  assign out_pc      = out_q.pc;
  assign out_inst    = out_q.inst;
  assign out_bus_err = out_q.bus_err;
  assign fwd_en      = out_q.valid & out_q.rd_en;
  assign fwd_addr    = out_q.rd_addr;
  assign fwd_data    = out_q.wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single accesses, hand sequences for flush/timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = '0;
  logic [31:0] in_store_data = '0;
  logic        in_rd_en = 1'b0;
  logic [4:0]  in_rd_addr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        flush = 1'b0;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = '0;
  logic        out_valid, out_rd_en, out_bus_err, fwd_en;
  logic [4:0]  out_rd_addr, fwd_addr;
  logic [31:0] out_wdata, out_pc, out_inst, fwd_data;

  always #5 clk = ~clk;

  mem_stage #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_store_data(in_store_data), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata),
    .out_valid(out_valid), .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr),
    .out_wdata(out_wdata), .out_pc(out_pc), .out_inst(out_inst), .out_bus_err(out_bus_err),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] result;
    logic [31:0] sdata;
    logic        rd_en;
    logic [4:0]  rd;
    int          gnt_dly;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_bus_wd;
    logic [31:0] e_wd;
    logic        e_rd_en;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
    return {17'd0, f3, rd, op};
  endfunction

  function automatic vec_t mk_vec(input string name, input logic [31:0] inst,
                                  input logic [31:0] result, input logic [31:0] sdata,
                                  input logic rd_en, input logic [4:0] rd, input int gnt_dly,
                                  input logic [31:0] rdata, input logic [31:0] e_addr,
                                  input logic [3:0] e_be, input logic [31:0] e_bus_wd,
                                  input logic [31:0] e_wd, input logic e_rd_en);
    vec_t v;
    v.name = name; v.inst = inst; v.result = result; v.sdata = sdata;
    v.rd_en = rd_en; v.rd = rd; v.gnt_dly = gnt_dly; v.rdata = rdata;
    v.e_addr = e_addr; v.e_be = e_be; v.e_bus_wd = e_bus_wd; v.e_wd = e_wd;
    v.e_rd_en = e_rd_en;
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] result,
                       input logic [31:0] sdata, input logic rd_en, input logic [4:0] rd,
                       input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_result = result; in_store_data = sdata;
    in_rd_en = rd_en; in_rd_addr = rd; in_pc = pc;
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    logic is_ld, is_st;
    is_ld = (v.inst[6:0] == 7'b0000011);
    is_st = (v.inst[6:0] == 7'b0100011);
    chk({v.name, "/in_ready_pre"}, in_ready, 1);
    drive(v.inst, v.result, v.sdata, v.rd_en, v.rd, pc);
    tick();
    in_valid = 1'b0;
    if (is_ld || is_st) begin
      for (int k = 0; k <= v.gnt_dly; k++) begin
        chk({v.name, "/req"}, dbus_req, 1);
        chk({v.name, "/addr"}, dbus_addr, v.e_addr);
        chk({v.name, "/be"}, dbus_be, v.e_be);
        chk({v.name, "/we"}, dbus_we, is_st);
        if (is_st) chk({v.name, "/bus_wdata"}, dbus_wdata, v.e_bus_wd);
        chk({v.name, "/early_valid"}, out_valid, 0);
        if (k == v.gnt_dly) dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
      end
      if (is_ld) begin
        chk({v.name, "/wait_valid"}, out_valid, 0);
        dbus_rvalid = 1'b1; dbus_rdata = v.rdata;
        tick();
        dbus_rvalid = 1'b0;
      end
    end
    chk({v.name, "/out_valid"}, out_valid, 1);
    chk({v.name, "/bus_err"}, out_bus_err, 0);
    chk({v.name, "/out_rd_en"}, out_rd_en, v.e_rd_en);
    chk({v.name, "/out_rd_addr"}, out_rd_addr, v.rd);
    chk({v.name, "/out_pc"}, out_pc, pc);
    chk({v.name, "/out_inst"}, out_inst, v.inst);
    if (!is_st) chk({v.name, "/out_wdata"}, out_wdata, v.e_wd);
    chk({v.name, "/fwd_en"}, fwd_en, v.e_rd_en);
    if (v.e_rd_en) begin
      chk({v.name, "/fwd_addr"}, fwd_addr, v.rd);
      chk({v.name, "/fwd_data"}, fwd_data, v.e_wd);
    end
    chk({v.name, "/in_ready"}, in_ready, 1);
    tick();
    chk({v.name, "/pulse_end"}, out_valid, 0);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk_vec("ori",  mk_inst(3'b110, 5'd5, 7'h13), 32'h0000_00FF, 0, 1, 5, 0, 0,
                     0, 0, 0, 32'h0000_00FF, 1);
    tbl[1]  = mk_vec("add_x0", mk_inst(3'b000, 5'd0, 7'h33), 32'h0000_1234, 0, 1, 0, 0, 0,
                     0, 0, 0, 32'h0000_1234, 0);
    tbl[2]  = mk_vec("sb", mk_inst(3'b000, 5'd0, 7'h23), 32'h1000_0003, 32'h0000_00A5, 0, 0, 2,
                     0, 32'h1000_0000, 4'b1000, 32'hA5A5_A5A5, 0, 0);
    tbl[3]  = mk_vec("sh", mk_inst(3'b001, 5'd0, 7'h23), 32'h1000_0006, 32'h0000_BEEF, 0, 0, 0,
                     0, 32'h1000_0004, 4'b1100, 32'hBEEF_BEEF, 0, 0);
    tbl[4]  = mk_vec("sw", mk_inst(3'b010, 5'd0, 7'h23), 32'h1000_0008, 32'hDEAD_BEEF, 0, 0, 1,
                     0, 32'h1000_0008, 4'b1111, 32'hDEAD_BEEF, 0, 0);
    tbl[5]  = mk_vec("lb", mk_inst(3'b000, 5'd7, 7'h03), 32'h2000_0001, 0, 1, 7, 0,
                     32'h0000_8000, 32'h2000_0000, 4'b0010, 0, 32'hFFFF_FF80, 1);
    tbl[6]  = mk_vec("lbu", mk_inst(3'b100, 5'd7, 7'h03), 32'h2000_0001, 0, 1, 7, 0,
                     32'h0000_8000, 32'h2000_0000, 4'b0010, 0, 32'h0000_0080, 1);
    tbl[7]  = mk_vec("lh", mk_inst(3'b001, 5'd8, 7'h03), 32'h2000_0002, 0, 1, 8, 1,
                     32'h8001_0000, 32'h2000_0000, 4'b1100, 0, 32'hFFFF_8001, 1);
    tbl[8]  = mk_vec("lhu", mk_inst(3'b101, 5'd8, 7'h03), 32'h2000_0002, 0, 1, 8, 0,
                     32'h8001_0000, 32'h2000_0000, 4'b1100, 0, 32'h0000_8001, 1);
    tbl[9]  = mk_vec("lw", mk_inst(3'b010, 5'd9, 7'h03), 32'h2000_0004, 0, 1, 9, 0,
                     32'h1234_5678, 32'h2000_0004, 4'b1111, 0, 32'h1234_5678, 1);
    tbl[10] = mk_vec("lw_x0", mk_inst(3'b010, 5'd0, 7'h03), 32'h2000_0004, 0, 1, 0, 0,
                     32'h1234_5678, 32'h2000_0004, 4'b1111, 0, 32'h1234_5678, 0);
    tbl[11] = mk_vec("lb_lane3", mk_inst(3'b000, 5'd10, 7'h03), 32'h2000_0007, 0, 1, 10, 0,
                     32'h7F00_0000, 32'h2000_0004, 4'b1000, 0, 32'h0000_007F, 1);

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst/in_ready", in_ready, 1);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/dbus_req", dbus_req, 0);
    chk("rst/dbus_be", dbus_be, 0);
    chk("rst/out_wdata", out_wdata, 0);
    chk("rst/fwd_en", fwd_en, 0);

    for (int i = 0; i < 12; i++) begin
      run_vec(tbl[i], 32'h0000_0100 + 32'(i * 4));
      $display("vector %0d %s done", i, tbl[i].name);
    end

    // Response timeout, then late rvalid drained.
    drive(mk_inst(3'b010, 5'd3, 7'h03), 32'h4000_0000, 0, 1, 3, 32'h200);
    tick(); in_valid = 1'b0;
    dbus_gnt = 1'b1; tick(); dbus_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("tmo/no_valid", out_valid, 0);
      tick();
    end
    chk("tmo/out_valid", out_valid, 1);
    chk("tmo/bus_err", out_bus_err, 1);
    chk("tmo/rd_en", out_rd_en, 0);
    chk("tmo/fwd_en", fwd_en, 0);
    chk("tmo/in_ready_drain", in_ready, 0);
    tick();
    chk("tmo/drain_hold", in_ready, 0);
    dbus_rvalid = 1'b1; tick(); dbus_rvalid = 1'b0;
    chk("tmo/in_ready_back", in_ready, 1);
    chk("tmo/no_extra_valid", out_valid, 0);
    $display("sequence timeout done");

    // rvalid on the timeout cycle wins.
    drive(mk_inst(3'b010, 5'd4, 7'h03), 32'h4000_0010, 0, 1, 4, 32'h204);
    tick(); in_valid = 1'b0;
    dbus_gnt = 1'b1; tick(); dbus_gnt = 1'b0;
    tick(); tick(); tick();
    dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_0001; tick(); dbus_rvalid = 1'b0;
    chk("race/out_valid", out_valid, 1);
    chk("race/bus_err", out_bus_err, 0);
    chk("race/wdata", out_wdata, 32'hCAFE_0001);
    chk("race/in_ready", in_ready, 1);
    tick();
    $display("sequence rvalid_vs_timeout done");

    // Flush in WAIT, drain, then a normal ALU op.
    drive(mk_inst(3'b010, 5'd6, 7'h03), 32'h5000_0000, 0, 1, 6, 32'h208);
    tick(); in_valid = 1'b0;
    dbus_gnt = 1'b1; tick(); dbus_gnt = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fwait/no_valid", out_valid, 0);
    chk("fwait/drain", in_ready, 0);
    dbus_rvalid = 1'b1; tick(); dbus_rvalid = 1'b0;
    chk("fwait/no_valid2", out_valid, 0);
    chk("fwait/in_ready", in_ready, 1);
    run_vec(mk_vec("after_flush", mk_inst(3'b000, 5'd12, 7'h13), 32'h0000_0777, 0, 1, 12, 0,
                   0, 0, 0, 0, 32'h0000_0777, 1), 32'h20C);
    $display("sequence flush_wait done");

    // Flush in REQ before grant.
    drive(mk_inst(3'b010, 5'd0, 7'h23), 32'h6000_0000, 32'h1, 0, 0, 32'h210);
    tick(); in_valid = 1'b0;
    chk("freq/req", dbus_req, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("freq/req_drop", dbus_req, 0);
    chk("freq/in_ready", in_ready, 1);
    chk("freq/no_valid", out_valid, 0);
    tick();
    chk("freq/no_valid2", out_valid, 0);
    $display("sequence flush_req done");

    // Flush on the grant cycle: store completes silently, load drains.
    drive(mk_inst(3'b010, 5'd0, 7'h23), 32'h6000_0004, 32'h2, 0, 0, 32'h214);
    tick(); in_valid = 1'b0;
    dbus_gnt = 1'b1; flush = 1'b1; tick(); dbus_gnt = 1'b0; flush = 1'b0;
    chk("fgnt_st/no_valid", out_valid, 0);
    chk("fgnt_st/in_ready", in_ready, 1);
    drive(mk_inst(3'b010, 5'd2, 7'h03), 32'h6000_0008, 0, 1, 2, 32'h218);
    tick(); in_valid = 1'b0;
    dbus_gnt = 1'b1; flush = 1'b1; tick(); dbus_gnt = 1'b0; flush = 1'b0;
    chk("fgnt_ld/drain", in_ready, 0);
    dbus_rvalid = 1'b1; tick(); dbus_rvalid = 1'b0;
    chk("fgnt_ld/no_valid", out_valid, 0);
    chk("fgnt_ld/in_ready", in_ready, 1);
    $display("sequence flush_gnt done");

    // Flush alongside in_valid: nothing accepted.
    drive(mk_inst(3'b000, 5'd5, 7'h13), 32'h0000_0055, 0, 1, 5, 32'h21C);
    flush = 1'b1; tick(); flush = 1'b0; in_valid = 1'b0;
    chk("fin/no_valid", out_valid, 0);
    chk("fin/in_ready", in_ready, 1);
    $display("sequence flush_input done");

    // Reset mid-transaction.
    drive(mk_inst(3'b010, 5'd1, 7'h03), 32'h7000_0000, 0, 1, 1, 32'h220);
    tick(); in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid/req", dbus_req, 0);
    chk("rstmid/in_ready", in_ready, 1);
    chk("rstmid/out_valid", out_valid, 0);
    $display("sequence reset_mid done");

    // Misaligned LH.
    drive(mk_inst(3'b001, 5'd11, 7'h03), 32'h3000_0001, 0, 1, 11, 32'h224);
    tick(); in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis/req", dbus_req, 0);
    chk("mis/out_valid", out_valid, 1);
    chk("mis/bus_err", out_bus_err, 1);
    chk("mis/rd_en", out_rd_en, 0);
    tick();
    chk("mis/req2", dbus_req, 0);
    chk("mis/pulse_end", out_valid, 0);
`else
    chk("mis/req", dbus_req, 1);
    chk("mis/addr", dbus_addr, 32'h3000_0000);
    chk("mis/be", dbus_be, 4'b0011);
    dbus_gnt = 1'b1; tick(); dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h0000_ABCD; tick(); dbus_rvalid = 1'b0;
    chk("mis/out_valid", out_valid, 1);
    chk("mis/bus_err", out_bus_err, 0);
    chk("mis/wdata", out_wdata, 32'hFFFF_ABCD);
    tick();
`endif
    $display("sequence misaligned_lh done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU stage.
- Registers the ALU result bundle (result, rd enable/address, pc, inst).
- Performs load/store transactions on a req/gnt/rvalid data bus and stalls upstream while an access is outstanding.
- Presents a one-cycle-valid writeback bundle plus forwarding info to the writeback stage and the decode stage.

Parameters:
- RESP_TIMEOUT, 255: max cycles waiting for dbus_rvalid after grant; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ALU bundle valid
- in_ready  out  1  stage can accept a bundle
- in_result  in  32  ALU result (effective address for load/store)
- in_store_data  in  32  rs2 value for stores
- in_rd_en  in  1  rd write enable
- in_rd_addr  in  5  rd index
- in_pc  in  32  instruction pc
- in_inst  in  32  instruction word
- flush  in  1  kill in-flight/incoming instruction
- dbus_req  out  1  bus request
- dbus_we  out  1  write
- dbus_addr  out  32  word-aligned address
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-replicated store data
- dbus_gnt  in  1  request accepted
- dbus_rvalid  in  1  read data valid
- dbus_rdata  in  32  read data
- out_valid  out  1  writeback bundle valid (1-cycle pulse)
- out_rd_en  out  1  rd write enable
- out_rd_addr  out  5  rd index
- out_wdata  out  32  writeback data
- out_pc  out  32  pc
- out_inst  out  32  instruction
- out_bus_err  out  1  access failed (timeout or misaligned)
- fwd_en  out  1  forwarding valid (equals out_valid & out_rd_en)
- fwd_addr  out  5  forwarded rd
- fwd_data  out  32  forwarded value

Behaviour:
- Reset: all outputs 0; in_ready 1; state IDLE; timeout counter 0.
- Decode from in_inst[6:0]: LOAD 7'b0000011, STORE 7'b0100011, anything else is ALU-only.
- Width from in_inst[14:12]:
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- in_ready = (state==IDLE). A transfer occurs on in_valid & in_ready & !flush.
- ALU-only: latency 1. Next cycle out_valid=1 and out_wdata=in_result.
- rd gating: out_rd_en = in_rd_en & (rd_addr!=0).

FSM:
- IDLE: on load/store accept, latch the bundle, go to REQ.
- REQ:
  - dbus_req=1; addr/we/be/wdata held stable until dbus_gnt.
  - Load granted: go to WAIT.
  - Store granted: go to IDLE; out_valid=1 next cycle with out_rd_en=0.
- WAIT:
  - Count cycles.
  - On dbus_rvalid: extract data, out_valid=1 next cycle, go to IDLE.
  - If the count reaches RESP_TIMEOUT first: out_valid=1, out_bus_err=1, out_rd_en=0, go to DRAIN.
- DRAIN: discard until dbus_rvalid, then go to IDLE. in_ready is 0 in this state.

Bus lane rules:
- dbus_addr = {addr[31:2],2'b00}.
- dbus_be:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
  - Loads: same widths.
- dbus_wdata: byte replicated 4x, half replicated 2x, word as-is.

Load extraction:
- Select lane by addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Flush:
- Flush with in_valid: the bundle is not accepted.
- Flush in REQ before gnt: drop dbus_req, go to IDLE, no out_valid.
- Flush in REQ on the gnt cycle: the transaction is committed; it proceeds but out_valid is suppressed. A load goes to DRAIN; a store goes to IDLE.
- Flush in WAIT: go to DRAIN; out_valid is suppressed.
- Flush in IDLE with no transfer: no effect.

Simultaneous events:
- dbus_gnt & dbus_rvalid in the same cycle for the same access never occur; the bus guarantees rvalid at least 1 cycle after gnt.
- rvalid on the same cycle the timeout is reached: rvalid wins.
- Reset mid-transaction: return to IDLE immediately; the bus is required to be reset together with this stage.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no bus request. Next cycle out_valid=1, out_bus_err=1, out_rd_en=0.
- Undefined: low address bits are masked to natural alignment (half: addr[0]=0, word: addr[1:0]=0) and the access proceeds normally; out_bus_err comes only from timeout.

Decomposition:
- Shared package cpu_defines:
  - opcode constants (INST_TYPE_LOAD, INST_TYPE_STORE)
  - funct3 load/store constants
  - mem_stage FSM state encoding (IDLE, REQ, WAIT, DRAIN)
- Sub-module mem_load_align: combinational lane select plus sign/zero extension. Inputs: rdata, addr[1:0], funct3. Output: 32-bit result.

Test Plan:
- ORI bundle, in_result=32'h0000_00FF, rd=5, no flush -> next cycle out_valid=1, out_wdata=32'h0000_00FF, fwd_en=1, fwd_addr=5; in_ready stays 1.
- SB, addr=32'h1000_0003, store_data=32'h0000_00A5, gnt after 2 cycles -> dbus_addr=32'h1000_0000, be=4'b1000, wdata=32'hA5A5_A5A5, held stable 3 cycles; out_valid with out_rd_en=0.
- LB, addr=32'h2000_0001, rdata=32'h0000_8000 -> out_wdata=32'hFFFF_FF80; same with LBU -> 32'h0000_0080.
- LW, gnt then no rvalid, RESP_TIMEOUT=4 -> out_bus_err=1 after 4 wait cycles, out_rd_en=0; a later rvalid is absorbed and in_ready returns to 1.
- Flush asserted in WAIT for LW -> no out_valid; the following rvalid is drained; the next ALU op completes normally.
- LH at addr=32'h3000_0001: with MEM_MISALIGN_TRAP_EN -> dbus_req never asserted, out_bus_err=1; without it -> dbus_addr=32'h3000_0000, be=4'b0011.
